sdram_seq_ctrl: RTL

//  Command sequencer for the 16-bit single-data-rate SDRAM on the 100 MHz board domain. Runs the power-up init.

---
 rtl/sdram_pkg.sv | 45 ++++
 rtl/sdram_ref_timer.sv | 33 +++
 rtl/sdram_seq_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: WORK_CS state codes, {CS_N,RAS_N,CAS_N,WE_N} command
// encodings and address field widths. The data-path block keys off codes 5/6/7.
package sdram_pkg;

  localparam int ADDR_W = 24;
  localparam int BA_W   = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int A_W    = 13;

  typedef enum logic [3:0] {
    WS_INIT_WAIT = 4'h0,
    WS_INIT_PRE  = 4'h1,
    WS_INIT_REF  = 4'h2,
    WS_INIT_MRS  = 4'h3,
    WS_IDLE      = 4'h4,
    WS_RD_LAT    = 4'h5,
    WS_RD_CAP    = 4'h6,
    WS_WRITE     = 4'h7,
    WS_ACTIVE    = 4'h8,
    WS_PRECH     = 4'h9,
    WS_AREF      = 4'hA
  } work_cs_e;

  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_NOP  = 4'b0111;
  localparam cmd_t CMD_ACT  = 4'b0011;
  localparam cmd_t CMD_RD   = 4'b0101;
  localparam cmd_t CMD_WR   = 4'b0100;
  localparam cmd_t CMD_PRE  = 4'b0010;
  localparam cmd_t CMD_REF  = 4'b0001;
  localparam cmd_t CMD_MRS  = 4'b0000;

  // Burst length 1, sequential, CAS latency in A[6:4].
  function automatic logic [A_W-1:0] mode_word(input int cas);
    logic [2:0] cl;
    cl = cas[2:0];
    return {6'b0, cl, 4'b0};
  endfunction

  function automatic logic [A_W-1:0] col_word(input logic [COL_W-1:0] col, input logic ap);
    return {2'b00, ap, 1'b0, col};
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval counter: free-runs while enabled, raises pending every
// REF_INT clocks; clear has priority so an expiry while pending is dropped.
module sdram_ref_timer #(
  parameter int REF_INT = 780
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pend_o
);

  localparam int CW = $clog2(REF_INT);

  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          expire;

  assign expire = en_i && (cnt_q == CW'(REF_INT - 1));
  assign pend_o = pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (en_i) cnt_q <= expire ? '0 : cnt_q + CW'(1);
      if (clr_i)       pend_q <= 1'b0;
      else if (expire) pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_seq_ctrl.sv
// SDRAM command sequencer: power-up init, refresh/write/read arbitration, registered pins.
// Build option SDR_AUTO_PRECHARGE_EN: READ/WRITE carry A10=1 and PRECH is a silent T_RP wait.
module sdram_seq_ctrl
  import sdram_pkg::*;
#(
  parameter int T_INIT  = 20000,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 7,
  parameter int T_MRD   = 2,
  parameter int T_RCD   = 2,
  parameter int CAS_LAT = 3,
  parameter int REF_INT = 780
) (
  input  logic              CLK_100M,
  input  logic              RST,
  input  logic              REQ_WR,
  input  logic              REQ_RD,
  input  logic [ADDR_W-1:0] ADDR,
  output logic              REQ_ACK,
  output logic              DONE,
  output logic              INIT_DONE,
  output logic              SDR_CKE,
  output logic              SDR_CS_N,
  output logic              SDR_RAS_N,
  output logic              SDR_CAS_N,
  output logic              SDR_WE_N,
  output logic [BA_W-1:0]   SDR_BA,
  output logic [A_W-1:0]    SDR_A,
  output logic [1:0]        SDR_DQM,
  output logic [3:0]        WORK_CS,
  output logic [3:0]        TIME_CNT
);

`ifdef SDR_AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  localparam logic [3:0] TC_RP  = 4'(T_RP - 1);
  localparam logic [3:0] TC_RFC = 4'(T_RFC - 1);
  localparam logic [3:0] TC_MRD = 4'(T_MRD - 1);
  localparam logic [3:0] TC_RCD = 4'(T_RCD - 1);
  localparam logic [3:0] TC_CL  = 4'(CAS_LAT - 1);

  work_cs_e         state_q;
  logic [3:0]       tcnt_q;
  logic [14:0]      init_cnt_q;
  logic             ref2_q;
  logic             wr_op_q;
  logic [BA_W-1:0]  bank_q;
  logic [COL_W-1:0] col_q;
  logic             cke_q, ack_q, done_q, idone_q;
  cmd_t             cmd_q;
  logic [BA_W-1:0]  ba_q;
  logic [A_W-1:0]   a_q;
  logic             ref_pend, ref_clr;

  // Pending is consumed on the very edge that IDLE launches AUTO REFRESH.
  assign ref_clr = (state_q == WS_IDLE) && ref_pend;

  sdram_ref_timer #(.REF_INT(REF_INT)) u_ref_timer (
    .clk_i  (CLK_100M),
    .rst_i  (RST),
    .en_i   (idone_q),
    .clr_i  (ref_clr),
    .pend_o (ref_pend)
  );

  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      state_q    <= WS_INIT_WAIT;
      tcnt_q     <= '0;
      init_cnt_q <= '0;
      ref2_q     <= 1'b0;
      wr_op_q    <= 1'b0;
      bank_q     <= '0;
      col_q      <= '0;
      cke_q      <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      idone_q    <= 1'b0;
      cmd_q      <= CMD_NOP;
      ba_q       <= '0;
      a_q        <= '0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= '0;
      a_q    <= '0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      if (tcnt_q != 4'd0) tcnt_q <= tcnt_q - 4'd1;
      case (state_q)
        WS_INIT_WAIT: begin
          cke_q <= 1'b1;
          if (init_cnt_q == 15'(T_INIT - 1)) begin
            state_q <= WS_INIT_PRE;
            tcnt_q  <= TC_RP;
            cmd_q   <= CMD_PRE;
            a_q     <= 13'h0400;
          end else begin
            init_cnt_q <= init_cnt_q + 15'd1;
          end
        end
        WS_INIT_PRE: if (tcnt_q == 4'd0) begin
          state_q <= WS_INIT_REF;
          tcnt_q  <= TC_RFC;
          cmd_q   <= CMD_REF;
          ref2_q  <= 1'b0;
        end
        WS_INIT_REF: if (tcnt_q == 4'd0) begin
          if (!ref2_q) begin
            ref2_q <= 1'b1;
            tcnt_q <= TC_RFC;
            cmd_q  <= CMD_REF;
          end else begin
            state_q <= WS_INIT_MRS;
            tcnt_q  <= TC_MRD;
            cmd_q   <= CMD_MRS;
            a_q     <= mode_word(CAS_LAT);
          end
        end
        WS_INIT_MRS: if (tcnt_q == 4'd0) begin
          state_q <= WS_IDLE;
          idone_q <= 1'b1;
        end
        WS_IDLE: begin
          if (ref_pend) begin
            state_q <= WS_AREF;
            tcnt_q  <= TC_RFC;
            cmd_q   <= CMD_REF;
          end else if (REQ_WR || REQ_RD) begin
            state_q <= WS_ACTIVE;
            tcnt_q  <= TC_RCD;
            cmd_q   <= CMD_ACT;
            ba_q    <= ADDR[23:22];
            a_q     <= ADDR[21:9];
            ack_q   <= 1'b1;
            wr_op_q <= REQ_WR;
            bank_q  <= ADDR[23:22];
            col_q   <= ADDR[8:0];
          end
        end
        WS_ACTIVE: if (tcnt_q == 4'd0) begin
          ba_q <= bank_q;
          a_q  <= col_word(col_q, AP);
          if (wr_op_q) begin
            state_q <= WS_WRITE;
            cmd_q   <= CMD_WR;
            done_q  <= 1'b1;
          end else begin
            state_q <= WS_RD_LAT;
            tcnt_q  <= TC_CL;
            cmd_q   <= CMD_RD;
          end
        end
        WS_RD_LAT: if (tcnt_q == 4'd0) begin
          state_q <= WS_RD_CAP;
          done_q  <= 1'b1;
        end
        WS_RD_CAP, WS_WRITE: begin
          state_q <= WS_PRECH;
          tcnt_q  <= TC_RP;
          if (!AP) begin
            cmd_q <= CMD_PRE;
            ba_q  <= bank_q;
          end
        end
        WS_PRECH, WS_AREF: if (tcnt_q == 4'd0) state_q <= WS_IDLE;
        default: state_q <= WS_INIT_WAIT;
      endcase
    end
  end

  assign REQ_ACK   = ack_q;
  assign DONE      = done_q;
  assign INIT_DONE = idone_q;
  assign SDR_CKE   = cke_q;
  assign {SDR_CS_N, SDR_RAS_N, SDR_CAS_N, SDR_WE_N} = cmd_q;
  assign SDR_BA    = ba_q;
  assign SDR_A     = a_q;
  assign SDR_DQM   = 2'b00;
  assign WORK_CS   = state_q;
  assign TIME_CNT  = tcnt_q;

endmodule
